// File: rtl/fractal_sync_pkg.sv
// rtl/fractal_sync_pkg.sv - shared types and helpers for the N-port fractal_sync register file
package fractal_sync_pkg;

  typedef struct packed {
    logic id_err;
    logic dup_err;
  } err_flags_t;

  localparam int MAX_PORTS = 64;

  function automatic logic [MAX_PORTS-1:0] all_ones_mask(input int n);
    logic [MAX_PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fractal_sync_np_entry.sv
// rtl/fractal_sync_np_entry.sv - one barrier entry: arrival mask, watchdog age, done/timeout pulses
module fractal_sync_np_entry
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int TIMEOUT = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [N_PORTS-1:0] new_i,
  output logic [N_PORTS-1:0] mask_o,
  output logic               done_o,
  output logic               timeout_o
);

  localparam int TO_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [N_PORTS-1:0]  FULL     = N_PORTS'(all_ones_mask(N_PORTS));
  localparam logic [TO_WIDTH-1:0] AGE_LAST = (TIMEOUT > 0) ? TO_WIDTH'(TIMEOUT - 1) : '0;

  logic [N_PORTS-1:0]  mask_q, mask_d, nxt;
  logic [TO_WIDTH-1:0] age_q, age_d;
  logic                done_q, done_d, to_q, to_d;
  logic                complete, expire;

  always_comb begin
    nxt      = mask_q | new_i;
    complete = (nxt == FULL);
    expire   = (TIMEOUT != 0) && (mask_q != '0) && (age_q == AGE_LAST);
    mask_d   = nxt;
    age_d    = age_q;
    done_d   = 1'b0;
    to_d     = 1'b0;
    // Priority: clear, then completion, then watchdog expiry, then age tracking.
    if (clear_i) begin
      mask_d = '0;
      age_d  = '0;
    end else if (complete) begin
      mask_d = '0;
      age_d  = '0;
      done_d = 1'b1;
    end else if (expire) begin
      mask_d = '0;
      age_d  = '0;
      to_d   = 1'b1;
    end else if (new_i != '0) begin
      age_d = '0;
    end else if ((mask_q != '0) && (TIMEOUT != 0)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      age_q  <= '0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      mask_q <= mask_d;
      age_q  <= age_d;
      done_q <= done_d;
      to_q   <= to_d;
    end
  end

  assign mask_o    = mask_q;
  assign done_o    = done_q;
  assign timeout_o = to_q;

endmodule

// File: rtl/fractal_sync_np_local_rf.sv
// rtl/fractal_sync_np_local_rf.sv - N-port local sync register file with id decode, error flags and bypass
module fractal_sync_np_local_rf
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int N_REGS   = 4,
  parameter int ID_WIDTH = 2,
  parameter int TIMEOUT  = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i,
  input  logic [N_PORTS-1:0]                check_i,
  output logic [N_PORTS-1:0]                present_o,
  output logic [N_PORTS-1:0]                id_err_o,
  output logic [N_PORTS-1:0]                dup_err_o,
  output logic                              bypass_o,
  output logic [N_REGS-1:0]                 pending_o,
  output logic [N_REGS-1:0]                 done_o,
  output logic [N_REGS-1:0]                 timeout_o
);

  localparam logic [ID_WIDTH:0] NREGS_W = (ID_WIDTH + 1)'(N_REGS);

  logic [N_PORTS-1:0] mask    [N_REGS];
  logic [N_PORTS-1:0] new_arr [N_REGS];
  err_flags_t         err     [N_PORTS];
  logic [N_PORTS-1:0] id_ok;
  logic [N_PORTS-1:0] arrive;

  always_comb begin
    present_o = '0;
    id_err_o  = '0;
    dup_err_o = '0;
    id_ok     = '0;
    arrive    = '0;
    bypass_o  = &check_i;
    for (int r = 0; r < N_REGS; r++) new_arr[r] = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      id_ok[p]       = ({1'b0, id_i[p]} < NREGS_W);
      err[p].id_err  = check_i[p] & ~id_ok[p];
      err[p].dup_err = 1'b0;
      // Out-of-range ids never match an entry, so present/dup stay low for them.
      for (int r = 0; r < N_REGS; r++) begin
        if (id_i[p] == ID_WIDTH'(r)) begin
          present_o[p]   = |mask[r];
          err[p].dup_err = check_i[p] & mask[r][p];
        end
      end
      arrive[p] = check_i[p] & id_ok[p] & ~err[p].dup_err;
      for (int r = 0; r < N_REGS; r++) begin
        new_arr[r][p] = arrive[p] && (id_i[p] == ID_WIDTH'(r));
      end
      id_err_o[p]  = err[p].id_err;
      dup_err_o[p] = err[p].dup_err;
      bypass_o     = bypass_o & id_ok[p] & (id_i[p] == id_i[0]);
    end
  end

  for (genvar r = 0; r < N_REGS; r++) begin : g_entry
    fractal_sync_np_entry #(
      .N_PORTS (N_PORTS),
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear_i),
      .new_i     (new_arr[r]),
      .mask_o    (mask[r]),
      .done_o    (done_o[r]),
      .timeout_o (timeout_o[r])
    );
    assign pending_o[r] = |mask[r];
  end

  a_ports: assert property (@(posedge clk_i) N_PORTS >= 2);
  a_idw:   assert property (@(posedge clk_i) (2 ** ID_WIDTH) >= N_REGS);
  a_nox:   assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(check_i));

endmodule

// File: doc/fractal_sync_np_local_rf.md
Name: fractal_sync_np_local_rf

Overview:
- N-port successor of the 1D/2D local sync register files: each entry records a per-port arrival mask instead of a single toggle bit.
- An entry completes, and releases, only when every port has checked in on the same id, whether in one cycle (bypass) or across cycles.
- Adds duplicate-arrival detection, per-entry watchdog timeout with flush, a global clear, and registered per-entry done/timeout pulses.
- Sits at a fractal_sync tree node between child ports and the upstream node.

Parameters:
- N_PORTS, 4, number of participating ports (>=2).
- N_REGS, 4, number of barrier entries; valid ids are 0..N_REGS-1.
- ID_WIDTH, 2, id width; 2**ID_WIDTH >= N_REGS.
- TIMEOUT, 256, cycles an entry may stay pending before forced release; 0 disables.
- localparam TO_WIDTH = $clog2(TIMEOUT+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous flush of all entries and timers.
- id_i[N_PORTS]  in  ID_WIDTH  barrier id per port.
- check_i[N_PORTS]  in  1  arrival strobe per port, one cycle per arrival.
- present_o[N_PORTS]  out  1  comb; entry id_i[p] already has at least one pending arrival (current state).
- id_err_o[N_PORTS]  out  1  comb; check_i[p] asserted with id_i[p] >= N_REGS.
- dup_err_o[N_PORTS]  out  1  comb; check_i[p] asserted while mask[id_i[p]][p] is already set.
- bypass_o  out  1  comb; all check_i high, all ids equal, all valid.
- pending_o[N_REGS]  out  1  registered; mask nonzero.
- done_o[N_REGS]  out  1  registered one-cycle pulse; entry completed.
- timeout_o[N_REGS]  out  1  registered one-cycle pulse; entry force-released by the watchdog.

Behaviour:
- State per entry:
  - mask[N_PORTS] arrival bits.
  - age[TO_WIDTH] counter.
- Reset (rst_i):
  - All masks and ages are 0.
  - pending_o, done_o and timeout_o are 0.
  - Comb outputs follow their inputs immediately.
- Valid arrival for port p:
  - Requires check_i[p], id valid, and no dup error.
  - Invalid or duplicate arrivals are dropped; only the error flag fires, in the same cycle.
- Per entry r, each cycle:
  - new_r = OR over valid arrivals with id==r of onehot(p).
  - nxt = mask[r] | new_r.
  - If nxt == all-ones: mask <= 0, age <= 0, done_o[r] <= 1 on the next edge (latency 1 from the last arrival).
  - Bypass is the same rule with mask[r]==0: no state is written and done_o fires next cycle.
  - Otherwise mask <= nxt.
- Several entries may complete in the same cycle; each gets its own done_o bit.
- Timeout:
  - While mask[r] != 0 and not completing, age increments.
  - age resets to 0 on any new arrival to r.
  - When age == TIMEOUT-1 and no completion: mask <= 0, age <= 0, timeout_o[r] <= 1 next cycle.
  - Completion in the same cycle wins: done only, no timeout.
  - With TIMEOUT = 0, age stays 0 and timeout_o never fires.
- clear_i:
  - Highest priority after reset: all masks and ages go to 0.
  - done_o and timeout_o are forced to 0 next cycle, even if completion coincides.
  - Arrivals in the clear cycle are discarded.
- An arrival in the cycle after completion starts a fresh episode of that entry.
- Reset mid-episode discards partial masks with no pulses.
- Assertions:
  - N_PORTS >= 2.
  - 2**ID_WIDTH >= N_REGS.
  - No X on check_i out of reset.

Decomposition:
- fractal_sync_pkg holds:
  - The error-flag struct type (id_err, dup_err).
  - A function to build the all-ones N_PORTS mask.
- One natural sub-module: fractal_sync_np_entry.
  - Owns one mask and age counter.
  - Inputs: new arrivals, clear.
  - Outputs: mask, done, timeout.
  - Instantiated N_REGS times.
- The top level handles id decode, error flags and bypass.

Test Plan:
1. Bypass: N_PORTS=4, all ports check id 2 in cycle 0 → bypass_o=1 in cycle 0; done_o=4'b0100 in cycle 1; pending_o stays 0.
2. Staggered arrivals on id 1:
   - Port0 at cycle 0, port1 at cycle 3, ports 2-3 at cycle 5.
   - pending_o[1]=1 during cycles 1-5; present_o high for ports 1-3 at their arrivals.
   - done_o[1] pulses at cycle 6; pending_o[1]=0 at cycle 6.
3. Duplicate and id errors:
   - Port0 checks id 0 twice (cycles 0 and 2) → dup_err_o[0]=1 in cycle 2 only; mask unchanged.
   - Port3 checks id 5 with N_REGS=4 → id_err_o[3]=1; no state change.
4. Timeout, TIMEOUT=8:
   - Port0 checks id 3 at cycle 0 and nothing follows → timeout_o[3] pulses at cycle 9; pending_o[3]=0 afterwards.
   - A second run with a port1 arrival at cycle 6 delays the timeout to cycle 15.
5. Concurrent completions:
   - Entries 0 and 1 each hold ports 1-3.
   - Cycle k: port0 on id 0 only → done_o=4'b0001 at k+1.
   - Then entry 1 completes separately; fill entry 2 via ports 0-2 and entry 3 via ports 1-3, then one cycle with port3→id2 and port0→id3 → done_o=4'b1100 at once.
6. Clear and reset:
   - Partial masks on ids 0 and 2, then clear_i coinciding with a completing arrival → no done_o, pending_o all 0 next cycle.
   - Repeat with rst_i asserted mid-cycle → outputs 0 asynchronously.
